multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle main control FSM for the RISC-V multi-cycle CPU; sits directly upstream of the ALU control decoder and drives its 7-bit `ALUOp` input. It sequences each instruction through IF/ID/EX/MEM/WB, drives all datapath enables and mux selects, waits on a memory-ready handshake, counts retired instructions and halts on ECALL.

## Interface
- `ADD_OP`, 7'b0010111: ALUOp value that forces the ALU control decoder to ADD, used for PC/address arithmetic.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `opcode`  in  7  instruction register bits [6:0].
- `bcond`  in  1  branch-taken result from the ALU, valid in EX.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `pc_write`, `ir_write`, `mem_read`, `mem_write`, `reg_write`, `i_or_d`, `pc_source`  out  1 each  datapath enables and selects.
- `alu_src_a`  out  2  00 PC, 01 oldPC, 10 rs1 reg, 11 zero.
- `alu_src_b`  out  2  00 rs2 reg, 01 const 4, 10 imm.
- `wb_sel`  out  2  00 ALUOut, 01 MDR, 10 PC.
- `alu_op`  out  7  to ALU control decoder.
- `num_inst`  out  32  retired-instruction count.
- `halted`  out  1  high once ECALL has been decoded.

## Operation
- States: IF, ID, EX, MEM, WB, HALT. Reset state IF.
- Outputs are a function of state, `opcode`, `bcond` and `mem_ready`. Unlisted signals default to 0. `alu_op` = `ADD_OP` except in EX, where it equals `opcode`.
- IF: `mem_read`=1, `i_or_d`=0, `alu_src_a`=00, `alu_src_b`=01. If `mem_ready`=0, stay in IF with no writes. If `mem_ready`=1, assert `ir_write` and `pc_write` with `pc_source`=0 (PC+4; the datapath latches oldPC on `ir_write`), then go to ID.
- ID: `alu_src_a`=01, `alu_src_b`=10. This computes the branch/JAL target into ALUOut.
  - ECALL (1110011) goes to HALT.
  - An unknown opcode is retired as a NOP and goes to IF.
  - All other opcodes go to EX.
- EX, per opcode:
  - R (0110011): A=10, B=00, then WB.
  - I-ALU (0010011): A=10, B=10, then WB.
  - LOAD (0000011) and STORE (0100011): A=10, B=10, then MEM.
  - LUI: A=11, B=10, then WB.
  - AUIPC: A=01, B=10, then WB.
  - BRANCH (1100011): A=10, B=00. `pc_write`=`bcond`, `pc_source`=1, then IF.
  - JAL: `reg_write`=1, `wb_sel`=10, `pc_write`=1, `pc_source`=1, then IF.
  - JALR: A=10, B=10, `reg_write`=1, `wb_sel`=10, `pc_write`=1, `pc_source`=0, then IF.
- MEM: `i_or_d`=1. LOAD asserts `mem_read`; STORE asserts `mem_write`.
  - Hold in MEM while `mem_ready`=0.
  - When `mem_ready`=1: LOAD goes to WB; STORE retires and goes to IF.
- WB: `reg_write`=1. `wb_sel`=01 for LOAD, 00 otherwise. Then IF.
- HALT: absorbing state; all enables 0, `halted`=1. Only `reset` exits.
- `num_inst` increments by 1 on each transition into IF or HALT from ID/EX/MEM/WB. It wraps modulo 2^32.

## Timing
- While `reset`=1, all enables are forced to 0. On the first cycle after release: state IF, `num_inst`=0, `halted`=0, `alu_op`=`ADD_OP`.
- Minimum cycles per instruction with `mem_ready` tied high:
  - 3: BRANCH, JAL, JALR.
  - 4: R, I, LUI, AUIPC, STORE.
  - 5: LOAD.
  - 2: ECALL (into HALT).
- Each `mem_ready`=0 cycle in IF or MEM adds exactly one cycle. No register, PC or IR write happens during a stall.
- Reset mid-instruction: no partial writes occur; the next cycle is IF with the counter cleared.
- A `mem_ready` pulse outside IF/MEM is ignored.
- `halted` rises the cycle after ECALL is in ID. `num_inst` includes the ECALL.

## Structure
- Shared header (`riscv_defs.v`):
  - opcode constants;
  - state encodings (3-bit);
  - `alu_src_a`, `alu_src_b` and `wb_sel` select encodings;
  - `ADD_OP`.
- Single module, no sub-modules. The state register, next-state logic, output decode and counter are all in one file.

## Test plan
- ADD (0110011), `mem_ready`=1 → states IF,ID,EX,WB. `alu_op`=0110011 only in EX. `reg_write`=1 only in WB. `num_inst` goes 0→1.
- LW with `mem_ready` low 2 cycles in IF and 3 in MEM → 10 cycles total. No `ir_write` or `reg_write` during stalls. `wb_sel`=01 in WB.
- BEQ with `bcond`=0, then BEQ with `bcond`=1 → `pc_write` in EX is 0, then 1 with `pc_source`=1. Each takes 3 cycles.
- JAL, then JALR → EX asserts `reg_write`, `wb_sel`=10 and `pc_write`. `pc_source` is 1 for JAL and 0 for JALR.
- ECALL after 5 instructions → HALT, `halted`=1, `num_inst`=6, all enables 0 for ≥20 cycles.
- `reset` asserted during LW MEM → no `reg_write`. On the next cycle state is IF and `num_inst`=0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared RISC-V definitions for the multi-cycle control FSM: opcodes, state and select encodings.
// Latency: none, constants only; backpressure: not applicable.
package multicycle_control_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  // Forces the downstream ALU control decoder to ADD (same bit pattern as AUIPC).
  localparam logic [6:0] ADD_OP = 7'b0010111;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_A_ZERO  = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MDR = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  // Opcodes that have an EX stage; anything else (except ECALL) retires as a NOP.
  function automatic logic has_ex(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_LUI,
      OP_AUIPC, OP_BRANCH, OP_JAL, OP_JALR: has_ex = 1'b1;
      default:                              has_ex = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V main control FSM: IF/ID/EX/MEM/WB sequencing, datapath enables, retire counter, ECALL halt.
// Latency: 2-5 cycles per instruction; backpressure: holds in IF/MEM with no writes while mem_ready is low.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        bcond,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        i_or_d,
  output logic        pc_source,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  wb_sel,
  output logic [6:0]  alu_op,
  output logic [31:0] num_inst,
  output logic        halted
);

  state_t state;
  state_t state_nxt;
  logic   retire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IF;
      num_inst <= '0;
    end else begin
      state <= state_nxt;
      if (retire) num_inst <= num_inst + 32'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    i_or_d    = 1'b0;
    pc_source = 1'b0;
    alu_src_a = SRC_A_PC;
    alu_src_b = SRC_B_RS2;
    wb_sel    = WB_ALU;
    alu_op    = ADD_OP;
    halted    = 1'b0;
    retire    = 1'b0;

    case (state)
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = S_ID;
        end
      end

      S_ID: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        if (opcode == OP_ECALL) state_nxt = S_HALT;
        else if (has_ex(opcode)) state_nxt = S_EX;
        else state_nxt = S_IF;
      end

      S_EX: begin
        alu_op = opcode;
        case (opcode)
          OP_R: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_RS2;
            state_nxt = S_WB;
          end
          OP_I: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_IMM;
            state_nxt = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_IMM;
            state_nxt = S_MEM;
          end
          OP_LUI: begin
            alu_src_a = SRC_A_ZERO;
            alu_src_b = SRC_B_IMM;
            state_nxt = S_WB;
          end
          OP_AUIPC: begin
            alu_src_a = SRC_A_OLDPC;
            alu_src_b = SRC_B_IMM;
            state_nxt = S_WB;
          end
          OP_BRANCH: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_RS2;
            pc_write  = bcond;
            pc_source = 1'b1;
            state_nxt = S_IF;
          end
          // Target was computed into ALUOut during ID; the ALU now adds nothing useful.
          OP_JAL: begin
            reg_write = 1'b1;
            wb_sel    = WB_PC;
            pc_write  = 1'b1;
            pc_source = 1'b1;
            state_nxt = S_IF;
          end
          OP_JALR: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_IMM;
            reg_write = 1'b1;
            wb_sel    = WB_PC;
            pc_write  = 1'b1;
            pc_source = 1'b0;
            state_nxt = S_IF;
          end
          default: state_nxt = S_IF;
        endcase
      end

      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = (opcode == OP_LOAD);
        mem_write = (opcode == OP_STORE);
        if (mem_ready) state_nxt = (opcode == OP_LOAD) ? S_WB : S_IF;
      end

      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = (opcode == OP_LOAD) ? WB_MDR : WB_ALU;
        state_nxt = S_IF;
      end

      S_HALT: halted = 1'b1;

      default: state_nxt = S_IF;
    endcase

    retire = (state != S_IF) && (state != S_HALT) &&
             ((state_nxt == S_IF) || (state_nxt == S_HALT));

    // Reset wins over whatever the current state would do this cycle.
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      retire    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle output checks against a phase-based reference model.
module tb_multicycle_control;

  localparam logic [6:0] R_OP   = 7'b0110011;
  localparam logic [6:0] I_OP   = 7'b0010011;
  localparam logic [6:0] LD_OP  = 7'b0000011;
  localparam logic [6:0] ST_OP  = 7'b0100011;
  localparam logic [6:0] LUI_OP = 7'b0110111;
  localparam logic [6:0] AUI_OP = 7'b0010111;
  localparam logic [6:0] BR_OP  = 7'b1100011;
  localparam logic [6:0] JAL_OP = 7'b1101111;
  localparam logic [6:0] JR_OP  = 7'b1100111;
  localparam logic [6:0] EC_OP  = 7'b1110011;
  localparam logic [6:0] ADDOP  = 7'b0010111;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        bcond;
  logic        mem_ready;
  logic        pc_write, ir_write, mem_read, mem_write, reg_write, i_or_d, pc_source;
  logic [1:0]  alu_src_a, alu_src_b, wb_sel;
  logic [6:0]  alu_op;
  logic [31:0] num_inst;
  logic        halted;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt;

  typedef struct packed {
    logic       pc_write, ir_write, mem_read, mem_write, reg_write, i_or_d, pc_source;
    logic [1:0] a, b, wb;
    logic [6:0] alu;
    logic       halted;
  } obs_t;

  typedef enum {P_IF, P_ID, P_EX, P_MEM, P_WB, P_HALT} phase_e;

  obs_t dut_obs;
  assign dut_obs = {pc_write, ir_write, mem_read, mem_write, reg_write, i_or_d, pc_source,
                    alu_src_a, alu_src_b, wb_sel, alu_op, halted};

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .i_or_d(i_or_d), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .wb_sel(wb_sel),
    .alu_op(alu_op), .num_inst(num_inst), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic known(input logic [6:0] op);
    return op inside {R_OP, I_OP, LD_OP, ST_OP, LUI_OP, AUI_OP, BR_OP, JAL_OP, JR_OP};
  endfunction

  // Expected outputs for one cycle, taken straight from the per-phase rules.
  function automatic obs_t model(input phase_e p, input logic [6:0] op, input logic bc,
                                 input logic rdy);
    obs_t o;
    o = '0;
    o.alu = ADDOP;
    case (p)
      P_IF: begin
        o.mem_read = 1'b1; o.b = 2'b01;
        if (rdy) begin o.ir_write = 1'b1; o.pc_write = 1'b1; end
      end
      P_ID: begin o.a = 2'b01; o.b = 2'b10; end
      P_EX: begin
        o.alu = op;
        case (op)
          R_OP:         begin o.a = 2'b10; o.b = 2'b00; end
          I_OP, LD_OP,
          ST_OP:        begin o.a = 2'b10; o.b = 2'b10; end
          LUI_OP:       begin o.a = 2'b11; o.b = 2'b10; end
          AUI_OP:       begin o.a = 2'b01; o.b = 2'b10; end
          BR_OP:        begin o.a = 2'b10; o.b = 2'b00; o.pc_write = bc; o.pc_source = 1'b1; end
          JAL_OP:       begin o.reg_write = 1'b1; o.wb = 2'b10; o.pc_write = 1'b1; o.pc_source = 1'b1; end
          JR_OP:        begin o.a = 2'b10; o.b = 2'b10; o.reg_write = 1'b1; o.wb = 2'b10; o.pc_write = 1'b1; end
          default: ;
        endcase
      end
      P_MEM: begin
        o.i_or_d = 1'b1;
        o.mem_read = (op == LD_OP);
        o.mem_write = (op == ST_OP);
      end
      P_WB: begin o.reg_write = 1'b1; o.wb = (op == LD_OP) ? 2'b01 : 2'b00; end
      P_HALT: o.halted = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic cyc(input phase_e p, input logic [6:0] op, input logic bc, input logic rdy,
                     input string tag);
    obs_t e;
    opcode = op; bcond = bc; mem_ready = rdy;
    @(negedge clk);
    e = model(p, op, bc, rdy);
    checks++;
    if (dut_obs !== e) begin
      errors++;
      $display("FAIL %s phase=%s op=%b: got %h required %h", tag, p.name(), op, dut_obs, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_cnt(input string tag);
    checks++;
    if (num_inst !== exp_cnt) begin
      errors++;
      $display("FAIL %s num_inst: got %0d required %0d", tag, num_inst, exp_cnt);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(1, 0));
  endfunction

  // One instruction from fetch to retirement; mem_ready is random where it must be ignored.
  task automatic run_instr(input logic [6:0] op, input logic bc, input int ifst, input int memst,
                           input string tag);
    for (int i = 0; i < ifst; i++) cyc(P_IF, op, bc, 1'b0, tag);
    cyc(P_IF, op, bc, 1'b1, tag);
    cyc(P_ID, op, bc, rbit(), tag);
    if (op == EC_OP) begin
      exp_cnt++;
      return;
    end
    if (known(op)) begin
      cyc(P_EX, op, bc, rbit(), tag);
      if (op == LD_OP || op == ST_OP) begin
        for (int i = 0; i < memst; i++) cyc(P_MEM, op, bc, 1'b0, tag);
        cyc(P_MEM, op, bc, 1'b1, tag);
      end
      if (op inside {R_OP, I_OP, LUI_OP, AUI_OP, LD_OP}) cyc(P_WB, op, bc, rbit(), tag);
    end
    exp_cnt++;
    check_cnt(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mem_ready = rbit();
      opcode = 7'($urandom);
      @(negedge clk);
      checks++;
      if ({pc_write, ir_write, mem_read, mem_write, reg_write} !== 5'b0) begin
        errors++;
        $display("FAIL reset_enables: got %b required 00000",
                 {pc_write, ir_write, mem_read, mem_write, reg_write});
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    exp_cnt = '0;
    cyc(P_IF, R_OP, 1'b0, 1'b0, "post_reset");
    check_cnt("post_reset");
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_add();
    do_reset();
    run_instr(R_OP, 1'b0, 0, 0, "add");
  endtask

  task automatic test_lw_stalls();
    run_instr(LD_OP, 1'b0, 2, 3, "lw_stall");
  endtask

  task automatic test_branch();
    run_instr(BR_OP, 1'b0, 0, 0, "beq_nt");
    run_instr(BR_OP, 1'b1, 0, 0, "beq_t");
  endtask

  task automatic test_jumps();
    run_instr(JAL_OP, rbit(), 0, 0, "jal");
    run_instr(JR_OP, rbit(), 0, 0, "jalr");
  endtask

  task automatic test_random();
    logic [6:0] pool [13];
    pool = '{R_OP, I_OP, LD_OP, ST_OP, LUI_OP, AUI_OP, BR_OP, JAL_OP, JR_OP,
             7'b0000000, 7'b1111111, 7'b0001111, 7'b1010101};
    for (int n = 0; n < 40; n++)
      run_instr(pool[$urandom_range(0, 12)], rbit(), $urandom_range(0, 3),
                $urandom_range(0, 3), "random");
  endtask

  task automatic test_mem_reset();
    do_reset();
    run_instr(R_OP, 1'b0, 0, 0, "pre_mr");
    run_instr(I_OP, 1'b0, 1, 0, "pre_mr");
    cyc(P_IF, LD_OP, 1'b0, 1'b1, "mr_lw");
    cyc(P_ID, LD_OP, 1'b0, 1'b0, "mr_lw");
    cyc(P_EX, LD_OP, 1'b0, 1'b0, "mr_lw");
    cyc(P_MEM, LD_OP, 1'b0, 1'b0, "mr_lw");
    reset = 1'b1; mem_ready = 1'b1; opcode = LD_OP;
    @(negedge clk);
    checks++;
    if ({reg_write, pc_write, ir_write, mem_read, mem_write} !== 5'b0) begin
      errors++;
      $display("FAIL mem_reset_enables: got %b required 00000",
               {reg_write, pc_write, ir_write, mem_read, mem_write});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_cnt = '0;
    check_cnt("mem_reset_cnt");
    cyc(P_IF, LD_OP, 1'b0, 1'b0, "mem_reset_if");
  endtask

  task automatic test_ecall();
    logic [6:0] pool [5];
    pool = '{R_OP, ST_OP, JAL_OP, LUI_OP, BR_OP};
    do_reset();
    for (int n = 0; n < 5; n++) run_instr(pool[n], rbit(), $urandom_range(0, 2), 1, "pre_ecall");
    run_instr(EC_OP, 1'b0, 1, 0, "ecall");
    for (int n = 0; n < 22; n++) cyc(P_HALT, 7'($urandom), rbit(), rbit(), "halt");
    check_cnt("halt_cnt");
    checks++;
    if (num_inst !== 32'd6) begin
      errors++;
      $display("FAIL ecall_count: got %0d required 6", num_inst);
    end
    do_reset();
    run_instr(AUI_OP, 1'b0, 0, 0, "after_halt");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; opcode = '0; bcond = 1'b0; mem_ready = 1'b0; exp_cnt = '0;
    @(posedge clk); #1;
    test_reset();
    test_add();
    test_lw_stalls();
    test_branch();
    test_jumps();
    test_random();
    test_mem_reset();
    test_ecall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
